// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: FSM and digit-index types, 7-segment codes, double-dabble step
package calc_disp_pkg;
  typedef enum logic {IDLE, CONVERT} state_t;
  typedef enum logic [1:0] {DIG_ONES, DIG_TENS, DIG_HUNS} digit_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  // One double-dabble step: +3 on nibbles >=5, then shift in the next binary bit
  function automatic logic [11:0] dab_step(input logic [11:0] b, input logic in);
    logic [11:0] a;
    for (int i = 0; i < 3; i++) a[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return 12'({a, in});
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high {g,f,e,d,c,b,a}; non-decimal codes go dark
//   digit  in  4  BCD digit
//   seg    out 7  segment pattern
module seg7_decode
  import calc_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = 7'h00;
    endcase
endmodule

// File: rtl/calc_display_driver.sv
// calc_display_driver: 8-bit binary to BCD converter with multiplexed 7-segment scan
//   clock     in   1  rising-edge clock
//   Reset     in   1  synchronous active-high reset
//   NumIn     in   8  value to convert
//   Load      in   1  start conversion (ignored while Busy)
//   Busy      out  1  conversion in progress (8 cycles)
//   Bcd       out 12  displayed value {hundreds, tens, ones}
//   Segments  out  7  decoded segments of the selected digit
//   DigitSel  out  3  one-hot digit select: 001 ones, 010 tens, 100 hundreds
module calc_display_driver
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 1024,
  parameter int LEADING_BLANK = 1
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [7:0]  NumIn,
  input  logic        Load,
  output logic        Busy,
  output logic [11:0] Bcd,
  output logic [6:0]  Segments,
  output logic [2:0]  DigitSel
);
  localparam int RW = $clog2(REFRESH_DIV);
  state_t state, state_nxt;
  logic [7:0] sh;
  logic [11:0] scr, scr_nxt;
  logic [2:0] step;
  logic [RW-1:0] rcnt;
  digit_t dig;
  logic [3:0] nib;
  logic [6:0] dec;
  logic blank;
  always_ff @(posedge clock) state <= Reset ? IDLE : state_nxt;
  always_comb state_nxt = state == IDLE ? (Load ? CONVERT : IDLE) : (step == 3'd7 ? IDLE : CONVERT);
  always_comb Busy = state == CONVERT;
  assign scr_nxt = dab_step(scr, sh[7]);
  // The eighth step commits straight to Bcd so the result lands on the edge that leaves CONVERT
  always_ff @(posedge clock)
    if (Reset) begin
      sh <= '0;
      scr <= '0;
      step <= '0;
      Bcd <= '0;
    end else if (state == IDLE) begin
      if (Load) begin
        sh <= NumIn;
        scr <= '0;
        step <= '0;
      end
    end else begin
      sh <= {sh[6:0], 1'b0};
      scr <= scr_nxt;
      step <= step + 3'd1;
      if (step == 3'd7) Bcd <= scr_nxt;
    end
  always_ff @(posedge clock)
    if (Reset) begin
      rcnt <= '0;
      dig <= DIG_ONES;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      dig <= dig == DIG_ONES ? DIG_TENS : dig == DIG_TENS ? DIG_HUNS : DIG_ONES;
    end else rcnt <= rcnt + 1'b1;
  always_comb begin
    nib = dig == DIG_HUNS ? Bcd[11:8] : dig == DIG_TENS ? Bcd[7:4] : Bcd[3:0];
    DigitSel = dig == DIG_HUNS ? 3'b100 : dig == DIG_TENS ? 3'b010 : 3'b001;
    blank = LEADING_BLANK != 0 && (dig == DIG_HUNS ? Bcd[11:8] == 4'd0 : dig == DIG_TENS && Bcd[11:4] == 8'd0);
    Segments = blank ? 7'h00 : dec;
  end
  seg7_decode u_dec (.digit(nib), .seg(dec));
endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: vectors, corner sequences and random traffic against an arithmetic model
module tb_calc_display_driver;
  logic clk = 0, rst = 1, load = 0;
  logic [7:0] num = 0;
  logic busy1, busy0;
  logic [11:0] bcd1, bcd0;
  logic [6:0] seg1, seg0;
  logic [2:0] sel1, sel0;
  int n_chk = 0, n_fail = 0;
  bit mon = 0;
  always #5 clk = ~clk;
  calc_display_driver #(.REFRESH_DIV(4), .LEADING_BLANK(1)) dut (
    .clock(clk), .Reset(rst), .NumIn(num), .Load(load),
    .Busy(busy1), .Bcd(bcd1), .Segments(seg1), .DigitSel(sel1));
  calc_display_driver #(.REFRESH_DIV(4), .LEADING_BLANK(0)) dut_nb (
    .clock(clk), .Reset(rst), .NumIn(num), .Load(load),
    .Busy(busy0), .Bcd(bcd0), .Segments(seg0), .DigitSel(sel0));
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  // Model: countdown of busy cycles, displayed number as an integer, cycles since reset
  int m_left = 0, m_val = 0, m_num = 0, m_cyc = 0;
  always @(posedge clk)
    if (rst) begin
      m_left <= 0;
      m_num <= 0;
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_num <= m_val;
      end else if (load) begin
        m_val <= num;
        m_left <= 8;
      end
    end
  function automatic logic [11:0] to_bcd(int n);
    return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + n % 10);
  endfunction
  function automatic logic [6:0] exp_seg(int n, int d, bit lb);
    int dv;
    dv = d == 2 ? n / 100 : d == 1 ? (n / 10) % 10 : n % 10;
    if (lb && ((d == 2 && n < 100) || (d == 1 && n < 10))) return 7'h00;
    return SEG[dv];
  endfunction
  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (mon) begin
      int d;
      d = (m_cyc / 4) % 3;
      check("mon_busy", busy1, m_left > 0);
      check("mon_bcd", bcd1, to_bcd(m_num));
      check("mon_sel", sel1, 3'b001 << d);
      check("mon_seg", seg1, exp_seg(m_num, d, 1));
      check("mon_nb_bcd", bcd0, to_bcd(m_num));
      check("mon_nb_sel", sel0, 3'b001 << d);
      check("mon_nb_seg", seg0, exp_seg(m_num, d, 0));
    end
  task automatic load_val(int v);
    num = 8'(v);
    load = 1;
    @(negedge clk);
    load = 0;
  endtask
  typedef struct { int n; logic [11:0] bcd; logic [6:0] so, st, sh; } vec_t;
  vec_t tbl [10];
  initial begin
    tbl[0] = '{255, 12'h255, 7'h6D, 7'h6D, 7'h5B};
    tbl[1] = '{7, 12'h007, 7'h07, 7'h00, 7'h00};
    tbl[2] = '{0, 12'h000, 7'h3F, 7'h00, 7'h00};
    tbl[3] = '{100, 12'h100, 7'h3F, 7'h3F, 7'h06};
    tbl[4] = '{42, 12'h042, 7'h5B, 7'h66, 7'h00};
    tbl[5] = '{9, 12'h009, 7'h6F, 7'h00, 7'h00};
    tbl[6] = '{10, 12'h010, 7'h3F, 7'h06, 7'h00};
    tbl[7] = '{199, 12'h199, 7'h6F, 7'h6F, 7'h06};
    tbl[8] = '{58, 12'h058, 7'h7F, 7'h6D, 7'h00};
    tbl[9] = '{63, 12'h063, 7'h4F, 7'h7D, 7'h00};
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_bcd", bcd1, 12'h000);
    check("rst_sel", sel1, 3'b001);
    check("rst_seg", seg1, 7'h3F);
    rst = 0;
    mon = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", busy1, 0);
      check("idle_bcd", bcd1, 12'h000);
    end
    foreach (tbl[i]) begin
      load_val(tbl[i].n);
      for (int c = 0; c < 8; c++) begin
        check("vec_busy_hi", busy1, 1);
        @(negedge clk);
      end
      check("vec_busy_lo", busy1, 0);
      check("vec_bcd", bcd1, tbl[i].bcd);
      for (int c = 0; c < 12; c++) begin
        int d;
        d = (m_cyc / 4) % 3;
        check("vec_seg", seg1, d == 2 ? tbl[i].sh : d == 1 ? tbl[i].st : tbl[i].so);
        @(negedge clk);
      end
    end
    load_val(100);
    for (int c = 0; c < 8; c++) begin
      check("drop_busy_hi", busy1, 1);
      if (c == 2) begin
        num = 42;
        load = 1;
      end
      @(negedge clk);
      load = 0;
    end
    check("drop_bcd", bcd1, 12'h100);
    repeat (3) begin
      check("drop_busy_lo", busy1, 0);
      @(negedge clk);
    end
    check("drop_bcd_hold", bcd1, 12'h100);
    load_val(200);
    for (int c = 0; c < 3; c++) begin
      check("abort_busy_hi", busy1, 1);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", busy1, 0);
    check("abort_bcd", bcd1, 12'h000);
    load_val(9);
    repeat (8) @(negedge clk);
    check("after_abort_bcd", bcd1, 12'h009);
    check("after_abort_busy", busy1, 0);
    rst = 1;
    load = 1;
    num = 77;
    @(negedge clk);
    rst = 0;
    load = 0;
    check("rst_load_busy", busy1, 0);
    check("rst_load_bcd", bcd1, 12'h000);
    @(negedge clk);
    check("rst_load_busy2", busy1, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    num = 123;
    load = 1;
    for (int i = 0; i < 16; i++) begin
      check("scan_sel", sel1, 3'b001 << ((i / 4) % 3));
      @(negedge clk);
      load = 0;
    end
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 59) == 0;
      load = $urandom_range(0, 3) == 0;
      num = 8'($urandom);
      @(negedge clk);
    end
    rst = 0;
    load = 0;
    repeat (10) @(negedge clk);
    mon = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_display_driver.md
CALC_DISPLAY_DRIVER -- requirements
Module: calc_display_driver

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  REFRESH_DIV, 1024, clock cycles each digit stays selected (>=2)
  LEADING_BLANK, 1, 1 = blank leading zero digits
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clock  input  1  single clock, rising edge
  Reset  input  1  synchronous, active-high reset
  NumIn  input  8  unsigned value to display
  Load  input  1  one-cycle request to convert and display NumIn
  Busy  output  1  conversion in progress
  Bcd  output  12  displayed value as BCD {hundreds, tens, ones}
  Segments  output  7  {g,f,e,d,c,b,a}, active-high
  DigitSel  output  3  one-hot, active-high: 001 ones, 010 tens, 100 hundreds
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have two states, IDLE and CONVERT.
REQ-005 In IDLE, Load=1 at edge k SHALL capture NumIn, clear the scratch BCD, and enter CONVERT.
REQ-006 CONVERT SHALL last exactly 8 cycles, one double-dabble step per cycle: add 3 to each scratch nibble >=5, then shift left 1, taking in the next NumIn bit MSB-first.
REQ-007 At edge k+8 the scratch SHALL commit to Bcd and the FSM SHALL return to IDLE.
REQ-008 Busy SHALL be 1 from after edge k through edge k+8 (8 cycles) and 0 otherwise.
REQ-009 Bcd SHALL hold its previous value during CONVERT.
REQ-010 Load while Busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-011 The hundreds nibble SHALL only take values 0-2; NumIn=255 SHALL yield Bcd=0x255.
REQ-012 A free-running counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance ones->tens->hundreds->ones.
REQ-013 The refresh counter SHALL run regardless of FSM state.
REQ-014 Segments SHALL be the decode of the selected Bcd digit in the same cycle as DigitSel.
REQ-015 Decode SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, >9=0x00.
REQ-016 When LEADING_BLANK=1:
  - Segments SHALL be 0x00 for hundreds when hundreds=0.
  - Segments SHALL be 0x00 for tens when hundreds=0 and tens=0.
  - The ones digit SHALL never be blanked.
  - DigitSel SHALL still be driven for blanked digits.

Reset
REQ-017 Reset=1 at an edge SHALL set: FSM=IDLE, Busy=0, Bcd=0x000, refresh counter=0, digit index=ones (DigitSel=001, Segments=0x3F).
REQ-018 Reset during CONVERT SHALL abort the conversion with no commit.
REQ-019 Reset and Load in the same cycle: Reset SHALL win and Load SHALL be dropped.

Structure
REQ-020 Package calc_disp_pkg SHALL hold:
  - the FSM state typedef (IDLE, CONVERT)
  - the digit-index typedef
  - the ten segment-code constants
REQ-021 Segment decode SHALL be the combinational sub-module seg7_decode (4-bit digit in, 7-bit Segments out), instantiated once after the digit mux.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, then hold idle -> Busy=0, Bcd=0x000, DigitSel=001, Segments=0x3F.
  - Load NumIn=255 -> Busy high exactly 8 cycles; Bcd=0x255 at k+8; scan gives ones 0x6D, tens 0x6D, hundreds 0x5B.
  - LEADING_BLANK=1, Load 7 -> Bcd=0x007; hundreds and tens Segments=0x00; ones=0x07. Load 0 -> ones=0x3F.
  - Load 100, then Load 42 at cycle 3 of Busy -> Bcd=0x100 and Busy drops after 8 cycles; the 42 request is lost.
  - Load 200, Reset at cycle 4 of CONVERT -> Busy=0, Bcd=0x000 next cycle; then Load 9 -> Bcd=0x009 after 8 cycles.
  - REFRESH_DIV=4 -> DigitSel 001,010,100,001 changing every 4 cycles, including during CONVERT.
